// File: rtl/ctrl_pkg.sv
// ctrl_pkg: control-bundle bit positions, forwarding select codes and stage register layouts
package ctrl_pkg;
    localparam int REG_W = 5;
    localparam int CTRL_W = 14;
    localparam int CTRL_REGDST = 13;
    localparam int CTRL_JUMP = 12;
    localparam int CTRL_BRANCH = 11;
    localparam int CTRL_MEMREAD = 10;
    localparam int CTRL_MEMTOREG = 9;
    localparam int CTRL_ALUOP_HI = 8;
    localparam int CTRL_ALUOP_LO = 7;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_ALUSRC = 5;
    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_JR = 3;
    localparam int CTRL_REG1 = 2;
    localparam int CTRL_JAL = 1;
    localparam int CTRL_BNE = 0;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [REG_W-1:0] RA_REG = 5'd31;
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
    } idex_t;
    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic mem_read;
        logic mem_write;
        logic jal;
        logic [REG_W-1:0] dst;
    } exmem_t;
    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic jal;
        logic [REG_W-1:0] dst;
    } memwb_t;
endpackage

// File: rtl/ctrl_fwd_unit.sv
// ctrl_fwd_unit: picks the newest in-flight producer of one EX source operand
module ctrl_fwd_unit
    import ctrl_pkg::*;
(
    input  logic [4:0] ex_src,
    input  logic       mem_regwrite,
    input  logic [4:0] mem_dst,
    input  logic       wb_regwrite,
    input  logic [4:0] wb_dst,
    output logic [1:0] sel
);
    always_comb begin
        sel = (mem_regwrite && mem_dst != '0 && mem_dst == ex_src) ? FWD_EXMEM :
              (wb_regwrite && wb_dst != '0 && wb_dst == ex_src) ? FWD_MEMWB : FWD_RF;
    end
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID/EX, EX/MEM, MEM/WB control registers with load-use stall,
// redirect flush and EX operand forwarding selects
module ctrl_pipe
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] id_ctrl,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        alu_zero,
    output logic        stall,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        redirect,
    output logic [1:0]  ex_aluop,
    output logic        ex_alusrc,
    output logic        ex_jr,
    output logic        ex_jump,
    output logic        mem_read,
    output logic        mem_write,
    output logic        wb_regwrite,
    output logic        wb_memtoreg,
    output logic        wb_jal,
    output logic [4:0]  wb_dst,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b
);
    idex_t  idex_q, idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;
    logic [REG_W-1:0] ex_dst;
    logic unused_reg1;

    assign unused_reg1 = idex_q.ctrl[CTRL_REG1];

    always_comb begin
        redirect = idex_q.ctrl[CTRL_JUMP] | idex_q.ctrl[CTRL_JR] |
                   (idex_q.ctrl[CTRL_BRANCH] & alu_zero) | (idex_q.ctrl[CTRL_BNE] & ~alu_zero);
        stall = idex_q.ctrl[CTRL_MEMREAD] && idex_q.rt != '0 &&
                (idex_q.rt == id_rs || idex_q.rt == id_rt) && !redirect;
        pc_write = ~stall;
        ifid_write = ~stall;
        ifid_flush = redirect;
        // A stall or a redirect both drop the ID instruction into a bubble
        idex_d = (stall || redirect) ? '0 : '{ctrl: id_ctrl, rs: id_rs, rt: id_rt, rd: id_rd};
        ex_dst = idex_q.ctrl[CTRL_JAL] ? RA_REG : idex_q.ctrl[CTRL_REGDST] ? idex_q.rd : idex_q.rt;
        exmem_d = '{regwrite: idex_q.ctrl[CTRL_REGWRITE], memtoreg: idex_q.ctrl[CTRL_MEMTOREG],
                    mem_read: idex_q.ctrl[CTRL_MEMREAD], mem_write: idex_q.ctrl[CTRL_MEMWRITE],
                    jal: idex_q.ctrl[CTRL_JAL], dst: ex_dst};
        memwb_d = '{regwrite: exmem_q.regwrite, memtoreg: exmem_q.memtoreg,
                    jal: exmem_q.jal, dst: exmem_q.dst};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign ex_aluop = idex_q.ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
    assign ex_alusrc = idex_q.ctrl[CTRL_ALUSRC];
    assign ex_jr = idex_q.ctrl[CTRL_JR];
    assign ex_jump = idex_q.ctrl[CTRL_JUMP];
    assign mem_read = exmem_q.mem_read;
    assign mem_write = exmem_q.mem_write;
    assign wb_regwrite = memwb_q.regwrite;
    assign wb_memtoreg = memwb_q.memtoreg;
    assign wb_jal = memwb_q.jal;
    assign wb_dst = memwb_q.dst;

    ctrl_fwd_unit u_fwd_a (
        .ex_src(idex_q.rs), .mem_regwrite(exmem_q.regwrite), .mem_dst(exmem_q.dst),
        .wb_regwrite(memwb_q.regwrite), .wb_dst(memwb_q.dst), .sel(fwd_a)
    );

    ctrl_fwd_unit u_fwd_b (
        .ex_src(idex_q.rt), .mem_regwrite(exmem_q.regwrite), .mem_dst(exmem_q.dst),
        .wb_regwrite(memwb_q.regwrite), .wb_dst(memwb_q.dst), .sel(fwd_b)
    );
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed instruction stream with a per-slot scoreboard of expected
// EX/MEM/WB control, plus explicit stall/redirect/forwarding expectations
module tb_ctrl_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] id_ctrl;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        alu_zero;
    logic        stall, pc_write, ifid_write, ifid_flush, redirect;
    logic [1:0]  ex_aluop;
    logic        ex_alusrc, ex_jr, ex_jump, mem_read, mem_write;
    logic        wb_regwrite, wb_memtoreg, wb_jal;
    logic [4:0]  wb_dst;
    logic [1:0]  fwd_a, fwd_b;

    localparam logic [13:0] NOP = 14'h0000;
    localparam logic [13:0] LW  = 14'h0630;
    localparam logic [13:0] SW  = 14'h0060;
    localparam logic [13:0] RT  = 14'h2110;
    localparam logic [13:0] BEQ = 14'h0880;
    localparam logic [13:0] BNE = 14'h0081;
    localparam logic [13:0] JAL = 14'h1012;
    localparam logic [13:0] LWJ = 14'h1630;

    typedef struct packed {
        logic [1:0] aluop;
        logic alusrc, jr, jump, mr, mw, rw, m2r, jal;
        logic [4:0] dst;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .alu_zero(alu_zero), .stall(stall), .pc_write(pc_write),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush), .redirect(redirect),
        .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc), .ex_jr(ex_jr), .ex_jump(ex_jump),
        .mem_read(mem_read), .mem_write(mem_write), .wb_regwrite(wb_regwrite),
        .wb_memtoreg(wb_memtoreg), .wb_jal(wb_jal), .wb_dst(wb_dst),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [13:0] c, input logic [4:0] rt, input logic [4:0] rd,
                                input logic bubble);
        exp_t e;
        e.aluop = c[8:7];
        e.alusrc = c[5];
        e.jr = c[3];
        e.jump = c[12];
        e.mr = c[10];
        e.mw = c[6];
        e.rw = c[4];
        e.m2r = c[9];
        e.jal = c[1];
        e.dst = c[1] ? 5'd31 : c[13] ? rd : rt;
        return bubble ? '0 : e;
    endfunction

    task automatic prefill();
        q.delete();
        q.push_back('0);
        q.push_back('0);
    endtask

    task automatic step(input logic [13:0] c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic z, input logic es, input logic er,
                        input logic [1:0] fa, input logic [1:0] fb);
        exp_t e, m, w;
        id_ctrl = c;
        id_rs = rs;
        id_rt = rt;
        id_rd = rd;
        alu_zero = z;
        #1;
        chk("stall", 16'(stall), 16'(es));
        chk("pc_write", 16'(pc_write), 16'(!es));
        chk("ifid_write", 16'(ifid_write), 16'(!es));
        chk("redirect", 16'(redirect), 16'(er));
        chk("ifid_flush", 16'(ifid_flush), 16'(er));
        chk("fwd_a", 16'(fwd_a), 16'(fa));
        chk("fwd_b", 16'(fwd_b), 16'(fb));
        q.push_back(mk(c, rt, rd, es | er));
        @(posedge clk);
        #1;
        e = q[2];
        m = q[1];
        w = q.pop_front();
        chk("ex_ctrl", 16'({ex_aluop, ex_alusrc, ex_jr, ex_jump}), 16'({e.aluop, e.alusrc, e.jr, e.jump}));
        chk("mem_ctrl", 16'({mem_read, mem_write}), 16'({m.mr, m.mw}));
        chk("wb_ctrl", 16'({wb_regwrite, wb_memtoreg, wb_jal}), 16'({w.rw, w.m2r, w.jal}));
        chk("wb_dst", 16'(wb_dst), 16'(w.dst));
    endtask

    initial begin
        rst_n = 1'b0;
        id_ctrl = NOP;
        id_rs = '0;
        id_rt = '0;
        id_rd = '0;
        alu_zero = 1'b0;
        #3;
        chk("rst_stall", 16'(stall), 16'd0);
        chk("rst_pc_write", 16'({pc_write, ifid_write}), 16'b11);
        chk("rst_outs", 16'({redirect, ifid_flush, ex_aluop, ex_alusrc, ex_jr, ex_jump,
                             mem_read, mem_write, wb_regwrite, wb_memtoreg, wb_jal}), 16'd0);
        chk("rst_wb_dst", 16'(wb_dst), 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prefill();
        // load-use: one bubble, then forward from MEM/WB
        step(LW,  1, 2, 0,  0, 0, 0, 2'b00, 2'b00);
        step(RT,  2, 5, 6,  0, 1, 0, 2'b00, 2'b00);
        step(RT,  2, 5, 6,  0, 0, 0, 2'b00, 2'b00);
        step(NOP, 0, 0, 0,  0, 0, 0, 2'b01, 2'b00);
        // back-to-back producer/consumer forwards from EX/MEM
        step(RT,  1, 1, 3,  0, 0, 0, 2'b00, 2'b00);
        step(RT,  3, 3, 7,  0, 0, 0, 2'b00, 2'b00);
        step(NOP, 0, 0, 0,  0, 0, 0, 2'b10, 2'b10);
        // one NOP between producer and consumer forwards from MEM/WB
        step(RT,  9, 9, 3,  0, 0, 0, 2'b00, 2'b00);
        step(NOP, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        step(RT,  3, 3, 10, 0, 0, 0, 2'b00, 2'b00);
        step(NOP, 0, 0, 0,  0, 0, 0, 2'b01, 2'b01);
        // branches
        step(BEQ, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        step(RT,  1, 1, 11, 1, 0, 1, 2'b00, 2'b00);
        step(BEQ, 0, 0, 0,  1, 0, 0, 2'b00, 2'b00);
        step(RT,  1, 1, 11, 0, 0, 0, 2'b00, 2'b00);
        step(BNE, 0, 0, 0,  1, 0, 0, 2'b00, 2'b00);
        step(NOP, 0, 0, 0,  0, 0, 1, 2'b00, 2'b00);
        // jal reaches WB with $31
        step(JAL, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        step(NOP, 0, 0, 0,  0, 0, 1, 2'b00, 2'b00);
        step(NOP, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        step(NOP, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        // redirect beats load-use stall
        step(LWJ, 0, 4, 0,  0, 0, 0, 2'b00, 2'b00);
        step(RT,  4, 0, 12, 0, 0, 1, 2'b00, 2'b00);
        // $0 never stalls or forwards
        step(LW,  0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        step(RT,  0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        step(RT,  0, 0, 13, 0, 0, 0, 2'b00, 2'b00);
        step(NOP, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        // EX/MEM wins over MEM/WB
        step(RT,  1, 1, 5,  0, 0, 0, 2'b00, 2'b00);
        step(RT,  1, 1, 5,  0, 0, 0, 2'b00, 2'b00);
        step(RT,  5, 5, 6,  0, 0, 0, 2'b00, 2'b00);
        step(NOP, 0, 0, 0,  0, 0, 0, 2'b10, 2'b10);
        step(SW,  0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        step(NOP, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        step(LW,  0, 2, 0,  0, 0, 0, 2'b00, 2'b00);
        // asynchronous reset in the middle of a stall
        id_ctrl = RT;
        id_rs = 5'd2;
        id_rt = 5'd5;
        id_rd = 5'd6;
        #1;
        chk("pre_rst_stall", 16'(stall), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", 16'(stall), 16'd0);
        chk("mid_rst_pc_write", 16'({pc_write, ifid_write}), 16'b11);
        chk("mid_rst_outs", 16'({redirect, ex_aluop, ex_alusrc, mem_read, mem_write,
                                 wb_regwrite, wb_jal}), 16'd0);
        chk("mid_rst_wb_dst", 16'(wb_dst), 16'd0);
        rst_n = 1'b1;
        prefill();
        step(RT,  2, 5, 6,  0, 0, 0, 2'b00, 2'b00);
        step(NOP, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
Consumer end of the ID-stage control decoder. Takes the 14-bit decoded control bundle and register specifiers from ID, and carries them through the ID/EX, EX/MEM and MEM/WB control registers. Generates the load-use stall back to the decoder and fetch stage, and flushes on EX-stage branch/jump redirects. Also produces forwarding selects for the EX operand muxes.

Parameters:
REG_W, 5, register specifier width
RA_REG, 31, link register written by jal/jalr

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
id_ctrl  in  14  decoded bundle: [13]RegDst [12]Jump [11]Branch [10]MemRead [9]MemtoReg [8:7]ALUOp [6]MemWrite [5]ALUSrc [4]RegWrite [3]jr [2]reg1 [1]jal [0]bne
id_rs  in  5  ID source reg 1
id_rt  in  5  ID source reg 2
id_rd  in  5  ID R-type destination
alu_zero  in  1  EX ALU zero flag
stall  out  1  load-use stall (combinational), fed to the decoder stall input
pc_write  out  1  PC enable
ifid_write  out  1  IF/ID enable
ifid_flush  out  1  clear IF/ID to NOP
redirect  out  1  EX-stage taken branch/jump, selects the PC target
ex_aluop  out  2  ID/EX ALUOp
ex_alusrc  out  1  ID/EX ALUSrc
ex_jr  out  1  ID/EX jr (PC source is rs)
ex_jump  out  1  ID/EX Jump
mem_read  out  1  EX/MEM MemRead
mem_write  out  1  EX/MEM MemWrite
wb_regwrite  out  1  MEM/WB RegWrite
wb_memtoreg  out  1  MEM/WB MemtoReg
wb_jal  out  1  MEM/WB jal (write-data select = PC+4)
wb_dst  out  5  MEM/WB destination
fwd_a  out  2  rs operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwd_b  out  2  rt operand select, same encoding

Behaviour:
- Reset (rst_n low, async): all three stage registers clear to 0. Outputs are therefore 0, with pc_write=1 and ifid_write=1 because stall=0.
- ID/EX captures id_ctrl, id_rs, id_rt, id_rd each rising edge. EX/MEM and MEM/WB shift every cycle and never stall. Control latency is 1/2/3 cycles to EX/MEM/WB.
- Destination resolves in EX: jal ? RA_REG : RegDst ? rd : rt. It is carried to EX/MEM and MEM/WB.
- redirect = ex.Jump | ex.jr | (ex.Branch & alu_zero) | (ex.bne & ~alu_zero). Combinational from ID/EX plus alu_zero.
- Load-use stall = ex.MemRead & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt) & ~redirect.
- On stall:
  - pc_write=0, ifid_write=0.
  - ID/EX loads a bubble (all 14 bits 0, specifiers 0).
  - Exactly one bubble per load-use pair.
- On redirect:
  - ifid_flush=1 and ID/EX loads a bubble next edge.
  - pc_write=1, ifid_write=1.
  - Redirect has priority over stall in the same cycle.
- Bubble slots never write memory or registers, and never redirect.
- Forwarding for rs (rt identical):
  - Select 10 when EX/MEM RegWrite & dst!=0 & dst==ex_rs.
  - Otherwise select 01 when MEM/WB RegWrite & dst!=0 & dst==ex_rs.
  - Otherwise 00. EX/MEM has priority over MEM/WB.
- Register $0 never matches for either stall or forwarding.
- Reset mid-stall: the stall clears immediately, since it is derived from the cleared ID/EX.

Decomposition:
- Package ctrl_pkg holds:
  - control-bundle bit-index constants (CTRL_REGDST=13 … CTRL_BNE=0) and CTRL_W=14;
  - FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01;
  - RA_REG.
- One natural sub-module, ctrl_fwd_unit: combinational forwarding compare, instantiated once per operand.

Test Plan:
- Reset with rst_n low mid-run -> all stage outputs 0 asynchronously; pc_write=1, stall=0.
- LW $2 (ctrl RegWrite|MemRead|MemtoReg|ALUSrc), then R-type with rs=2 -> stall=1 for exactly one cycle, ID/EX bubble, R-type re-enters EX with fwd_a=01.
- R-type dst $3, then R-type rs=3 rt=3 -> fwd_a=fwd_b=10; with one NOP between -> both 01.
- beq in EX with alu_zero=1 -> redirect=1, ifid_flush=1, next ID/EX all 0; with alu_zero=0 -> redirect=0. bne with zero=0 -> redirect=1.
- jal in pipeline -> three cycles later wb_dst=31, wb_regwrite=1, wb_jal=1.
- LW $4 in EX with redirect (Jump) and id_rs=4 in the same cycle -> stall=0, pc_write=1, ifid_flush=1; writes to $0 never forward or stall.
